// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state encoding, frame and counter widths,
// and the parity helper.
package uart_rx_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 13;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Expected parity bit for a data byte: even parity when odd == 0.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-stage synchronizer for the asynchronous RX line.
// Both stages reset to the idle-high level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o
);

    logic meta_q;
    logic sync_q;

    // Two flops in series; only the second stage feeds the receiver.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
        end
    end

    assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), optional parity, 1 stop; one-entry output buffer.
// Parity support is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD       = 5207,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_busy,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] BAUD_C = CNT_W'(BAUD);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(BAUD / 2);
`ifdef UART_RX_PARITY_EN
    localparam state_e AFTER_DATA = ST_PARITY;
`else
    localparam state_e AFTER_DATA = ST_STOP;
`endif

    logic              rx_s;
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        idx_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_bad_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              busy_q;
    logic              fe_q;
    logic              pe_q;
    logic              ov_q;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (rx),
        .rx_s_o (rx_s)
    );

    // Frame FSM, bit timing, output buffer and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            par_bad_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            fe_q <= 1'b0;
            pe_q <= 1'b0;
            ov_q <= 1'b0;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_C) begin
                        cnt_q     <= '0;
                        idx_q     <= 3'd0;
                        par_bad_q <= 1'b0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            // Line back high at mid-start: treat as a glitch.
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BAUD_C) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= AFTER_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == BAUD_C) begin
                        cnt_q     <= '0;
                        par_bad_q <= (rx_s != parity_bit(shift_q, PARITY_ODD));
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_q == BAUD_C) begin
                        // Return to IDLE on the sample edge so a back-to-back start is caught.
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        if (!rx_s) begin
                            fe_q <= 1'b1;
                        end else if (par_bad_q) begin
                            pe_q <= 1'b1;
                        end else if (!valid_q || rx_ready) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ov_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 13'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = busy_q;
    assign frame_err = fe_q;
    assign overrun   = ov_q;

`ifdef UART_RX_PARITY_EN
    assign parity_err = pe_q;
`else
    logic unused_parity_s;
    assign parity_err      = 1'b0;
    assign unused_parity_s = pe_q ^ PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at BAUD=15 (16 clocks per bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int passed = 0;
    int total  = 0;
    int mon_cyc, mon_first, mon_valid, mon_busy, mon_fe, mon_pe, mon_ov;
    int mon_multi = 0;

`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    // Stop sample lands 3 + 7 + 16*(NB-1) edges after e0.
    localparam int FIRST_EXP = 10 + 16 * (NB - 1);

    always #5 clk = ~clk;

    uart_rx #(.BAUD(15), .PARITY_ODD(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic stop, input logic par);
`ifdef UART_RX_PARITY_EN
        return {stop, par, d, 1'b0};
`else
        return {1'b1, stop, d, 1'b0};
`endif
    endfunction

    task automatic clear_mon();
        mon_cyc = 0; mon_first = -1; mon_valid = 0; mon_busy = 0;
        mon_fe = 0; mon_pe = 0; mon_ov = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rx_valid && mon_first < 0) mon_first = mon_cyc;
        if (rx_valid)   mon_valid++;
        if (rx_busy)    mon_busy++;
        if (frame_err)  mon_fe++;
        if (parity_err) mon_pe++;
        if (overrun)    mon_ov++;
        if (int'(frame_err) + int'(parity_err) + int'(overrun) > 1) mon_multi++;
        mon_cyc++;
    endtask

    task automatic run(input logic [10:0] bits, input int nbits, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            rx = ((c / 16) < nbits) ? bits[c / 16] : 1'b1;
            step();
        end
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", rx_valid, 1'b0);
        check("reset_busy", rx_busy, 1'b0);
        check("reset_data", rx_data, 8'h00);
        check("reset_flags", {frame_err, parity_err, overrun}, 3'b000);
        rst = 1'b0;
        run(11'h7FF, 0, 5);

        // Clean 0xA5 with consumer ready
        rx_ready = 1'b1;
        clear_mon();
        run(mk_frame(8'hA5, 1'b1, 1'b0), NB, 200);
        check("a5_latency", mon_first, FIRST_EXP);
        check("a5_valid_cycles", mon_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_flags", mon_fe + mon_pe + mon_ov, 0);

        // Four-cycle low glitch
        clear_mon();
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (40) step();
        check("glitch_busy_cycles", mon_busy, 8);
        check("glitch_busy_end", rx_busy, 1'b0);
        check("glitch_valid", mon_valid, 0);
        check("glitch_flags", mon_fe + mon_pe + mon_ov, 0);

        // Stop bit low
        clear_mon();
        run(mk_frame(8'h3C, 1'b0, 1'b0), NB, 200);
        check("stoplow_frame_err", mon_fe, 1);
        check("stoplow_parity_err", mon_pe, 0);
        check("stoplow_valid", mon_valid, 0);
        check("stoplow_data_kept", rx_data, 8'hA5);

        // Back-to-back frames with consumer stalled
        rx_ready = 1'b0;
        clear_mon();
        run(mk_frame(8'h11, 1'b1, 1'b0), NB, NB * 16);
        run(mk_frame(8'h22, 1'b1, 1'b0), NB, 200);
        check("ovr_pulse", mon_ov, 1);
        check("ovr_held_data", rx_data, 8'h11);
        check("ovr_valid_held", rx_valid, 1'b1);
        rx_ready = 1'b1;
        step();
        check("ovr_accept_valid", rx_valid, 1'b0);
        check("ovr_accept_data", rx_data, 8'h11);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, parity bit must be 1
        clear_mon();
        run(mk_frame(8'h07, 1'b1, 1'b1), NB, 200);
        check("par_good_valid", mon_valid, 1);
        check("par_good_data", rx_data, 8'h07);
        check("par_good_err", mon_pe, 0);
        clear_mon();
        run(mk_frame(8'h07, 1'b1, 1'b0), NB, 200);
        check("par_bad_err", mon_pe, 1);
        check("par_bad_valid", mon_valid, 0);
`endif

        // Reset in the middle of data bit 4
        rx_ready = 1'b0;
        clear_mon();
        run(mk_frame(8'h5A, 1'b1, 1'b0), NB, 5 * 16 + 8);
        check("midrst_busy_before", rx_busy, 1'b1);
        rx = 1'b1;
        rst = 1'b1;
        step();
        check("midrst_busy", rx_busy, 1'b0);
        check("midrst_data", rx_data, 8'h00);
        check("midrst_valid_flags", {rx_valid, frame_err, parity_err, overrun}, 4'b0000);
        rst = 1'b0;
        run(11'h7FF, 0, 4);
        clear_mon();
        run(mk_frame(8'h5A, 1'b1, 1'b0), NB, 200);
        check("after_rst_data", rx_data, 8'h5A);
        check("after_rst_valid", rx_valid, 1'b1);
        check("after_rst_flags", mon_fe + mon_pe + mon_ov, 0);
        check("flags_exclusive", mon_multi, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
